// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Shares one memory port between the instruction-fetch (IF) and   |
// |            load/store (D) requesters. Round-robin arbitration, at most one |
// |            access in flight, response returned MEM_LATENCY cycles after    |
// |            the grant on the owning requester's rvalid strobe.              |
// | Ports    : clk, rst (async, active-high)                                   |
// |            if_req/if_addr -> if_gnt, if_rvalid/if_rdata                    |
// |            d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata            |
// |            mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int MEM_LATENCY = 1,   // 1..7
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic       OWN_IF   = 1'b0;
   localparam logic       OWN_D    = 1'b1;
   localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       wr_q,    wr_d;
   logic       last_q,  last_d;
   logic [2:0] cnt_q,   cnt_d;

   logic w_resp;
   logic w_elig;
   logic w_pick_d;
   logic w_gnt_if;
   logic w_gnt_d;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      wr_d      = wr_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      // The response cycle is also a grant slot, giving back-to-back accesses.
      w_resp   = (state_q == ST_WAIT) && (cnt_q == 3'd0);
      w_elig   = (state_q == ST_IDLE) || w_resp;
      // D wins when alone, or on a tie when IF was granted most recently.
      w_pick_d = d_req && (!if_req || (last_q == OWN_IF));
      // Grants are forced off while rst is high so every output reads 0.
      w_gnt_d  = !rst && w_elig && w_pick_d;
      w_gnt_if = !rst && w_elig && if_req && !w_pick_d;

      if (w_resp && !rst) begin
         if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            if (!wr_q) begin
               d_rdata = mem_rdata;
            end
         end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
         end
      end

      if (w_gnt_d) begin
         d_gnt     = 1'b1;
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (w_gnt_if) begin
         if_gnt    = 1'b1;
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end

      if (w_gnt_d || w_gnt_if) begin
         state_d = ST_WAIT;
         owner_d = w_gnt_d ? OWN_D : OWN_IF;
         wr_d    = w_gnt_d && d_we;
         last_d  = w_gnt_d ? OWN_D : OWN_IF;
         cnt_d   = CNT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
         cnt_d = cnt_q - 3'd1;
      end else if (w_resp) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         wr_q    <= 1'b0;
         last_q  <= OWN_IF;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Self-checking bench for mem_arbiter at MEM_LATENCY 1 and 3.     |
// |            Each instance has its own memory model, requesters and a        |
// |            transaction-level reference model checked every cycle.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          gap;
      bit          withdraw;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'h00500093 : (32'hC0DE0000 | (i * 32'h111));
   endfunction

   function automatic txn_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                               input int gap, input bit wdraw);
      txn_t t;
      t.addr = a; t.we = we; t.wdata = wd; t.gap = gap; t.withdraw = wdraw;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      txn_t t;
      t.addr     = $urandom;
      t.we       = $urandom_range(0, 1) == 1;
      t.wdata    = $urandom;
      t.gap      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      t.withdraw = $urandom_range(0, 7) == 0;
      return t;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 3;

      logic        rst = 1'b1;
      logic        mem_clear = 1'b1;
      logic        if_req = 1'b0;
      logic [31:0] if_addr = '0;
      logic        if_gnt, if_rvalid;
      logic [31:0] if_rdata;
      logic        d_req = 1'b0, d_we = 1'b0;
      logic [31:0] d_addr = '0, d_wdata = '0;
      logic        d_gnt, d_rvalid;
      logic [31:0] d_rdata;
      logic        mem_en, mem_we;
      logic [31:0] mem_addr, mem_wdata, mem_rdata;
      bit          fin = 1'b0;

      mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
         .if_rvalid(if_rvalid), .if_rdata(if_rdata),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
         .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
         .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
      );

      // Memory model: data for the address presented LAT cycles ago.
      logic [31:0] mem [64];
      logic [5:0]  aq  [LAT];
      always @(posedge clk) begin
         aq[0] <= mem_addr[7:2];
         for (int i = 1; i < LAT; i++) aq[i] <= aq[i-1];
         if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
         end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
         end
      end
      assign mem_rdata = mem[aq[LAT-1]];

      task automatic chk(input string t, input logic [63:0] a, input logic [63:0] e);
         check_val($sformatf("L%0d_%s", LAT, t), a, e);
      endtask

      // Reference model: one outstanding access with an absolute due cycle.
      bit          pend = 0, pend_d = 0, pend_we = 0, last_was_d = 0;
      logic [31:0] pend_data = '0;
      int          pend_due = 0, cyc = 0;
      logic [31:0] shadow [64];

      always @(negedge clk) begin
         bit due, elig, w_d, w_if;
         logic [31:0] e_addr, e_wdata;
         if (rst) begin
            chk("rst_ctrl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 0);
            chk("rst_maddr", mem_addr, 0);
            chk("rst_mwdata", mem_wdata, 0);
            chk("rst_rdata", if_rdata | d_rdata, 0);
            pend = 0;
            last_was_d = 0;
            if (mem_clear) for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
         end else begin
            due  = pend && (pend_due == cyc);
            elig = !pend || due;
            w_d  = elig && d_req && (!if_req || !last_was_d);
            w_if = elig && if_req && !w_d;
            e_addr  = w_d ? d_addr : (w_if ? if_addr : 32'h0);
            e_wdata = w_d ? d_wdata : 32'h0;
            chk("if_gnt", if_gnt, w_if);
            chk("d_gnt", d_gnt, w_d);
            chk("mem_en", mem_en, w_d || w_if);
            chk("mem_we", mem_we, w_d && d_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("if_rvalid", if_rvalid, due && !pend_d);
            chk("d_rvalid", d_rvalid, due && pend_d);
            chk("if_rdata", if_rdata, (due && !pend_d) ? pend_data : 32'h0);
            if (!(due && pend_d && pend_we))
               chk("d_rdata", d_rdata, (due && pend_d) ? pend_data : 32'h0);
            if (due) pend = 0;
            if (w_d || w_if) begin
               pend       = 1;
               pend_d     = w_d;
               pend_we    = w_d && d_we;
               pend_data  = shadow[e_addr[7:2]];
               pend_due   = cyc + LAT;
               last_was_d = w_d;
               if (pend_we) shadow[e_addr[7:2]] = d_wdata;
            end
         end
         cyc++;
      end

      // Requesters: enter and leave at posedge+1; hold request until granted.
      task automatic run_if(input txn_t t);
         bit got;
         got = 0;
         repeat (t.gap) begin if_req = 0; @(posedge clk); #1; end
         if_req = 1; if_addr = t.addr;
         for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            got = if_gnt;
            if (got || t.withdraw) break;
            @(posedge clk); #1;
         end
         if (!t.withdraw) chk("if_starve", got, 1);
         @(posedge clk); #1;
         if_req = 0;
      endtask

      task automatic run_d(input txn_t t);
         bit got;
         got = 0;
         repeat (t.gap) begin d_req = 0; @(posedge clk); #1; end
         d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
         for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            got = d_gnt;
            if (got || t.withdraw) break;
            @(posedge clk); #1;
         end
         if (!t.withdraw) chk("d_starve", got, 1);
         @(posedge clk); #1;
         d_req = 0;
      endtask

      initial begin
         repeat (3) @(posedge clk);
         #1;
         rst = 0;
         mem_clear = 0;
         // Single fetch of 0x10.
         run_if(mk(32'h10, 0, 0, 0, 0));
         repeat (4) begin @(posedge clk); #1; end
         // Tie: D first, then IF, then D again.
         fork
            run_if(mk(32'h14, 0, 0, 0, 0));
            begin
               run_d(mk(32'h20, 0, 0, 0, 0));
               run_d(mk(32'h24, 0, 0, 0, 0));
            end
         join
         repeat (4) begin @(posedge clk); #1; end
         // Store then load back.
         run_d(mk(32'h40, 1, 32'hDEADBEEF, 0, 0));
         run_d(mk(32'h40, 0, 0, 0, 0));
         repeat (4) begin @(posedge clk); #1; end
         // Reset while a D load is in flight, then a fresh fetch.
         run_d(mk(32'h80, 0, 0, 0, 0));
         rst = 1;
         @(posedge clk); #1;
         rst = 0;
         run_if(mk(32'h44, 0, 0, 1, 0));
         repeat (4) begin @(posedge clk); #1; end
         // D pulses for one cycle while the fetch is outstanding.
         fork
            run_if(mk(32'h48, 0, 0, 0, 0));
            run_d(mk(32'h4C, 0, 0, 1, 1));
         join
         repeat (4) begin @(posedge clk); #1; end
         // Random traffic from both requesters.
         fork
            for (int n = 0; n < 250; n++) run_if(rnd_txn());
            for (int n = 0; n < 250; n++) run_d(rnd_txn());
         join
         repeat (10) begin @(posedge clk); #1; end
         fin = 1;
      end
   end

   initial begin
      fork
         wait (g_inst[0].fin && g_inst[1].fin);
         #400000;
      join_any
      checks++;
      if (!(g_inst[0].fin && g_inst[1].fin)) begin
         failures++;
         $display("FAIL timeout got=0 exp=1");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data memory port between the instruction-fetch requester and the load/store requester, so the core can run from one unified memory. Sits between the core's fetch/LSU request ports and the `memory` instance. Grants one access at a time with round-robin fairness. Returns each response on a per-requester valid strobe after a fixed memory latency.

## Interface
- `MEM_LATENCY`, default 1: cycles from a `mem_en` pulse to valid `mem_rdata`. Legal range 1..7.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `if_req`  in  1  fetch request. Always a read.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch data valid this cycle.
- `if_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  1  data request is a write.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid, or store done.
- `d_rdata`  out  DATA_W  load data.
- `mem_en`  out  1  memory access strobe. One-cycle pulse per access.
- `mem_we`  out  1  memory write enable. Qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- **States**
  - IDLE: no access outstanding.
  - WAIT: one access outstanding. Holds the owner register (IF/D), the write flag, and a down-counter `cnt` (3 bits).
- **Grant eligibility.** A grant can issue in IDLE, or in WAIT on the response cycle (`cnt==0`). This allows back-to-back accesses.
- **Arbitration**
  - If only one request is asserted, it wins.
  - If both are asserted, the winner is the requester not granted most recently, tracked by the `last` register.
  - After reset, `last`=IF, so D wins the first tie.
- **On a grant (all in the same cycle)**
  - The winner's `*_gnt`=1 and `mem_en`=1.
  - `mem_we` = `d_we` if D wins, else 0.
  - `mem_addr`/`mem_wdata` are muxed combinationally from the winner.
  - Next-state registers: owner ← winner, write flag ← `mem_we`, `last` ← winner, `cnt` ← MEM_LATENCY-1, state ← WAIT.
- **In WAIT with `cnt`>0:** `cnt` decrements, no grants.
- **Response cycle (WAIT, `cnt==0`)**
  - The owner's `*_rvalid`=1 for exactly one cycle.
  - `*_rdata` = `mem_rdata` (combinational pass-through).
  - Store response: `d_rvalid` pulses as the write acknowledge; `d_rdata` is don't-care.
  - If no new grant issues in that cycle, state ← IDLE.
- **Requester obligations**
  - Hold `req`, `addr`, `we` and `wdata` stable until `gnt`.
  - `req` may be withdrawn before `gnt` with no effect.
  - `req` held after `gnt` is treated as a new request.
- **Output defaults:** outputs not being driven by a grant or response are 0, including `mem_*`, so that idle-cycle values are deterministic.
- **Reset (also mid-access):** state IDLE, `cnt` 0, owner IF, `last` IF. No `rvalid` is produced for an access that was in flight. All outputs are 0 while `rst` is high.

## Timing
- Grant is combinational from `req` in an eligible cycle (zero-cycle accept).
- Response arrives exactly MEM_LATENCY cycles after the grant cycle.
- Throughput is one access per MEM_LATENCY cycles. With MEM_LATENCY=1 this is one access per cycle.
- Worst-case wait for a continuously asserted request is one access by the other requester (no starvation).
- At most one access is outstanding. `if_gnt` and `d_gnt` are never both 1. `if_rvalid` and `d_rvalid` are never both 1.
- Combinational paths: `req`→`gnt`/`mem_*`, and `mem_rdata`→`*_rdata`. No combinational path from `mem_rdata` to any grant.

## Test plan
- **Single fetch, MEM_LATENCY=1:** `if_req`=1, `if_addr`=0x10 at cycle 0.
  - Cycle 0: `if_gnt`=1, `mem_en`=1, `mem_addr`=0x10, `mem_we`=0.
  - Cycle 1: `if_rvalid`=1, `if_rdata`=`mem_rdata` (0x00500093 from model).
- **Tie after reset:** both requests high at cycle 0.
  - Grant order: D at cycle 0, IF at cycle 1, D at cycle 2.
  - `d_rvalid`/`if_rvalid` alternate on cycles 1-3.
- **Store, MEM_LATENCY=1:** `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF.
  - Grant cycle: `mem_we`=1, `mem_wdata`=0xDEADBEEF.
  - Next cycle: `d_rvalid`=1.
  - A following load of 0x40 returns 0xDEADBEEF.
- **MEM_LATENCY=3, continuous `if_req`:** grants at cycles 0, 3 and 6; `if_rvalid` at cycles 3, 6 and 9; no `mem_en` on cycles 1-2.
- **Reset mid-access, MEM_LATENCY=3:** grant D load at cycle 0, assert `rst` at cycle 1, release at cycle 2.
  - No `d_rvalid` ever appears for that load.
  - A new `if_req` at cycle 3 is granted at cycle 3.
- **Withdrawn request:** `d_req` pulses for one cycle while the arbiter is in WAIT with `cnt`>0 → no `d_gnt`, no `mem_en`, no `d_rvalid`.
